hidden_layer_seq: RTL

HIDDEN_LAYER_SEQ -- requirements
Module: hidden_layer_seq

---
 rtl/hidden_layer_seq_if.sv | 30 +++
 rtl/hidden_layer_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hidden_layer_seq_if.sv
// rtl/hidden_layer_seq_if.sv - handshake and result bus between driver and hidden_layer_seq
interface hidden_layer_seq_if;
    logic        start_i;
    logic [15:0] feat_i;
    logic [7:0]  w_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [9:0]  x0_o;
    logic [9:0]  x1_o;
    logic [9:0]  x2_o;
    logic [9:0]  x3_o;
    logic [9:0]  x4_o;
    logic [9:0]  x5_o;
    logic [9:0]  x6_o;
    logic [9:0]  x7_o;

    modport master (
        output start_i, feat_i, w_i, w_valid_i,
        input  w_ready_o, busy_o, valid_o,
        input  x0_o, x1_o, x2_o, x3_o, x4_o, x5_o, x6_o, x7_o
    );

    modport slave (
        input  start_i, feat_i, w_i, w_valid_i,
        output w_ready_o, busy_o, valid_o,
        output x0_o, x1_o, x2_o, x3_o, x4_o, x5_o, x6_o, x7_o
    );
endinterface

// File: rtl/hidden_layer_seq.sv
// rtl/hidden_layer_seq.sv - sequential 4-input, 8-neuron hidden layer with streamed weights
module hidden_layer_seq #(
    parameter int SHIFT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hidden_layer_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] feat_q, feat_d;
    logic [2:0]  j_q, j_d;
    logic [1:0]  k_q, k_d;
    logic [13:0] acc_q, acc_d;
    logic [9:0]  work_q [8];
    logic [9:0]  work_d [8];
    logic [9:0]  x_q [8];
    logic [9:0]  x_d [8];

    logic        beat;
    logic [3:0]  feat_sel;
    logic [11:0] product;
    logic [13:0] sum;
    logic [13:0] shifted;
    logic [9:0]  sat;

    // Multiply-accumulate datapath for the current beat, including the neuron's final saturated value
    always_comb begin
        beat     = (state_q == ST_MAC) && bus.w_valid_i;
        feat_sel = feat_q[{k_q, 2'b00} +: 4];
        product  = {8'd0, feat_sel} * {4'd0, bus.w_i};
        sum      = acc_q + {2'b00, product};
        shifted  = sum >> SHIFT;
        sat      = (shifted > 14'd1023) ? 10'd1023 : shifted[9:0];
    end

    // Pass sequencing: capture features, walk neurons/taps on accepted beats, commit on the last beat
    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        for (int i = 0; i < 8; i++) begin
            work_d[i] = work_q[i];
            x_d[i]    = x_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    feat_d  = bus.feat_i;
                    j_d     = 3'd0;
                    k_d     = 2'd0;
                    acc_d   = 14'd0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (beat) begin
                    if (k_q == 2'd3) begin
                        work_d[j_q] = sat;
                        acc_d       = 14'd0;
                        k_d         = 2'd0;
                        j_d         = j_q + 3'd1;
                        // The final neuron lands in work and x on the same edge
                        if (j_q == 3'd7) begin
                            for (int i = 0; i < 8; i++) begin
                                x_d[i] = work_d[i];
                            end
                            state_d = ST_DONE;
                        end
                    end else begin
                        acc_d = sum;
                        k_d   = k_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial pass and clears the published results
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            feat_q  <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                x_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= work_d[i];
                x_q[i]    <= x_d[i];
            end
        end
    end

    assign bus.w_ready_o = (state_q == ST_MAC);
    assign bus.busy_o    = (state_q == ST_MAC) || (state_q == ST_DONE);
    assign bus.valid_o   = (state_q == ST_DONE);
    assign bus.x0_o      = x_q[0];
    assign bus.x1_o      = x_q[1];
    assign bus.x2_o      = x_q[2];
    assign bus.x3_o      = x_q[3];
    assign bus.x4_o      = x_q[4];
    assign bus.x5_o      = x_q[5];
    assign bus.x6_o      = x_q[6];
    assign bus.x7_o      = x_q[7];

endmodule
